pid_correction_unit: RTL and testbench

Sequential PID stage that turns a stream of signed wall-distance error samples into the signed steering correction consumed by the saturating unsigned/signed adder, which applies it to the base motor duty. One shared multiplier is time-multiplexed over the P, I and D terms by a small FSM. The result is scaled, saturated to the adder's signed operand range and presented with a one-cycle valid strobe. Samples arrive at the sensor rate (about 100 Hz), far slower than the clock, so the multi-cycle latency is harmless.

---
 rtl/pid_pkg.sv | 14 +
 rtl/sat_signed.sv | 23 ++
 rtl/pid_correction_unit.sv | 139 +++++++++++++
 tb/tb_pid_correction_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types and default widths for the PID, adder and PWM stages.
package pid_pkg;
  typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, OUT} pid_state_t;

  localparam int PID_UNSIGNED_WIDTH = 8;
  localparam int PID_ERR_WIDTH      = 12;
  localparam int PID_GAIN_WIDTH     = 8;
  localparam int PID_FRAC_BITS      = 4;
  localparam int PID_INT_WIDTH      = 16;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/sat_signed.sv
// Signed saturator: clamps IN_WIDTH to the OUT_WIDTH two's-complement range.
module sat_signed #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat_hi,
  output logic                        sat_lo
);
  // Value fits only when every bit above the output sign bit matches it.
  logic [IN_WIDTH-OUT_WIDTH:0] top;

  assign top    = din[IN_WIDTH-1:OUT_WIDTH-1];
  assign sat_hi = !din[IN_WIDTH-1] && (|top);
  assign sat_lo =  din[IN_WIDTH-1] && !(&top);

  always_comb begin
    dout = din[OUT_WIDTH-1:0];
    if (sat_hi)      dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (sat_lo) dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  end
endmodule

// File: rtl/pid_correction_unit.sv
// PID steering correction with one shared multiplier sequenced over P, I, D.
// Build option: PID_ANTI_WINDUP_EN holds the integrator while the output is pinned.
module pid_correction_unit
  import pid_pkg::*;
#(
  parameter int UNSIGNED_WIDTH = PID_UNSIGNED_WIDTH,
  parameter int ERR_WIDTH      = PID_ERR_WIDTH,
  parameter int GAIN_WIDTH     = PID_GAIN_WIDTH,
  parameter int FRAC_BITS      = PID_FRAC_BITS,
  parameter int INT_WIDTH      = PID_INT_WIDTH
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic                          sample_valid_in,
  input  logic signed [ERR_WIDTH-1:0]   error_in,
  input  logic [GAIN_WIDTH-1:0]         kp_in,
  input  logic [GAIN_WIDTH-1:0]         ki_in,
  input  logic [GAIN_WIDTH-1:0]         kd_in,
  output logic                          busy_out,
  output logic signed [UNSIGNED_WIDTH:0] correction_out,
  output logic                          correction_valid_out,
  output logic                          overrun_out
);
  localparam int DIFF_W = ERR_WIDTH + 1;
  localparam int OPB_W  = imax(INT_WIDTH, DIFF_W);
  localparam int PROD_W = GAIN_WIDTH + 1 + OPB_W;
  localparam int ACC_W  = imax(GAIN_WIDTH + INT_WIDTH, GAIN_WIDTH + ERR_WIDTH + 1) + 3;
  localparam int OUT_W  = UNSIGNED_WIDTH + 1;

  pid_state_t state, next_state;

  logic signed [ERR_WIDTH-1:0] err_q, prev_err;
  logic [GAIN_WIDTH-1:0]       kp_q, ki_q, kd_q;
  logic signed [DIFF_W-1:0]    diff_q, diff_next;
  logic signed [INT_WIDTH-1:0] integ, integ_sat;
  logic signed [INT_WIDTH:0]   integ_sum;
  logic signed [ACC_W-1:0]     acc, acc_term, acc_shift;
  logic signed [GAIN_WIDTH:0]  mul_a;
  logic signed [OPB_W-1:0]     mul_b;
  logic signed [PROD_W-1:0]    prod;
  logic signed [OUT_W-1:0]     out_sat;
  logic                        out_hi, out_lo, sat_hi_q, sat_lo_q, windup_hold;
  logic                        int_sat_unused_hi, int_sat_unused_lo;

  assign diff_next = DIFF_W'(error_in) - DIFF_W'(prev_err);
  assign integ_sum = (INT_WIDTH+1)'(integ) + (INT_WIDTH+1)'(error_in);
  assign busy_out  = (state != IDLE);

`ifdef PID_ANTI_WINDUP_EN
  assign windup_hold = (sat_hi_q && !error_in[ERR_WIDTH-1] && (|error_in)) ||
                       (sat_lo_q &&  error_in[ERR_WIDTH-1]);
`else
  logic sat_flags_unused;
  assign sat_flags_unused = sat_hi_q ^ sat_lo_q;
  assign windup_hold      = 1'b0;
`endif

  sat_signed #(.IN_WIDTH(INT_WIDTH+1), .OUT_WIDTH(INT_WIDTH)) u_sat_int (
    .din(integ_sum), .dout(integ_sat), .sat_hi(int_sat_unused_hi), .sat_lo(int_sat_unused_lo)
  );

  sat_signed #(.IN_WIDTH(ACC_W), .OUT_WIDTH(OUT_W)) u_sat_out (
    .din(acc_shift), .dout(out_sat), .sat_hi(out_hi), .sat_lo(out_lo)
  );

  // Shared multiplier: gain operand is zero-extended so the product stays signed.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_P: begin mul_a = {1'b0, kp_q}; mul_b = OPB_W'(err_q);  end
      MUL_I: begin mul_a = {1'b0, ki_q}; mul_b = OPB_W'(integ);  end
      MUL_D: begin mul_a = {1'b0, kd_q}; mul_b = OPB_W'(diff_q); end
      default: ;
    endcase
  end

  assign prod      = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign acc_term  = ACC_W'(prod);
  assign acc_shift = acc >>> FRAC_BITS;

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid_in) next_state = MUL_P;
      MUL_P:   next_state = MUL_I;
      MUL_I:   next_state = MUL_D;
      MUL_D:   next_state = OUT;
      OUT:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      err_q                <= '0;
      prev_err             <= '0;
      kp_q                 <= '0;
      ki_q                 <= '0;
      kd_q                 <= '0;
      diff_q               <= '0;
      integ                <= '0;
      acc                  <= '0;
      correction_out       <= '0;
      correction_valid_out <= 1'b0;
      sat_hi_q             <= 1'b0;
      sat_lo_q             <= 1'b0;
      overrun_out          <= 1'b0;
    end else begin
      correction_valid_out <= 1'b0;
      if (sample_valid_in && state != IDLE) overrun_out <= 1'b1;
      case (state)
        IDLE: if (sample_valid_in) begin
          err_q    <= error_in;
          kp_q     <= kp_in;
          ki_q     <= ki_in;
          kd_q     <= kd_in;
          diff_q   <= diff_next;
          prev_err <= error_in;
          if (!windup_hold) integ <= integ_sat;
        end
        MUL_P:        acc <= acc_term;
        MUL_I, MUL_D: acc <= acc + acc_term;
        OUT: begin
          correction_out       <= out_sat;
          correction_valid_out <= 1'b1;
          sat_hi_q             <= out_hi;
          sat_lo_q             <= out_lo;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pid_correction_unit.sv
// Randomized scoreboard bench for pid_correction_unit against an integer PID model.
module tb_pid_correction_unit;
  logic              clk = 1'b0;
  logic              reset_in = 1'b1;
  logic              sample_valid_in = 1'b0;
  logic signed [11:0] error_in = '0;
  logic [7:0]        kp_in = '0, ki_in = '0, kd_in = '0;
  logic              busy_out;
  logic signed [8:0] correction_out;
  logic              correction_valid_out;
  logic              overrun_out;

  pid_correction_unit dut (
    .clk_in(clk), .reset_in(reset_in), .sample_valid_in(sample_valid_in),
    .error_in(error_in), .kp_in(kp_in), .ki_in(ki_in), .kd_in(kd_in),
    .busy_out(busy_out), .correction_out(correction_out),
    .correction_valid_out(correction_valid_out), .overrun_out(overrun_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int val; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int tests = 0, fails = 0;

  // Behavioural model state: integrator, last error, last output saturation (+1/-1/0).
  int m_integ = 0, m_prev = 0, m_sat = 0, m_last = 0;

  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int model(input int e, input int kp, input int ki, input int kd);
    int diff, acc, q;
    bit hold;
    diff = e - m_prev;
    m_prev = e;
    hold = 1'b0;
`ifdef PID_ANTI_WINDUP_EN
    hold = (m_sat > 0 && e > 0) || (m_sat < 0 && e < 0);
`endif
    if (!hold) m_integ = clamp(m_integ + e, -32768, 32767);
    acc = kp * e + ki * m_integ + kd * diff;
    q = acc >>> 4;
    m_sat = (q > 255) ? 1 : (q < -256) ? -1 : 0;
    m_last = clamp(q, -256, 255);
    return m_last;
  endfunction

  // Monitor: every valid pulse must match the head of the scoreboard, on time.
  always @(negedge clk) begin
    if (correction_valid_out) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL extra_valid: got pulse with value %0d, want no pulse (cycle %0d)",
                 correction_out, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("correction", int'(correction_out), mon_e.val);
        chk("latency", cyc, mon_e.cyc);
      end
    end else if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
      mon_e = sbq.pop_front();
      tests++; fails++;
      $display("FAIL missing_valid: got no pulse, want value %0d by cycle %0d", mon_e.val, mon_e.cyc);
    end
  end

  // Called at a negedge; returns five negedges later, when the unit is IDLE again.
  task automatic send(input int e, input int kp, input int ki, input int kd);
    logic [4:0] bp;
    exp_t x;
    sample_valid_in = 1'b1;
    error_in = 12'(e); kp_in = 8'(kp); ki_in = 8'(ki); kd_in = 8'(kd);
    x.val = model(e, kp, ki, kd);
    x.cyc = cyc + 5;
    sbq.push_back(x);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        sample_valid_in = 1'b0;
        error_in = 12'($urandom); kp_in = 8'($urandom); ki_in = 8'($urandom); kd_in = 8'($urandom);
      end
      bp[4-i] = busy_out;
    end
    chk("busy_window", int'(bp), int'(5'b11110));
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    sample_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_in = 1'b0;
    m_integ = 0; m_prev = 0; m_sat = 0; m_last = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_corr"},    int'(correction_out), 0);
    chk({tag, "_valid"},   int'(correction_valid_out), 0);
    chk({tag, "_busy"},    int'(busy_out), 0);
    chk({tag, "_overrun"}, int'(overrun_out), 0);
  endtask

  initial begin
    exp_t x;
    int gap;
    repeat (3) @(negedge clk);
    do_reset();
    check_idle_zero("reset");

    // Proportional path, then the held output between pulses
    send(100, 16, 0, 0);
    repeat (3) @(negedge clk);
    chk("hold_value", int'(correction_out), 100);
    // Output saturation at both ends
    send(300, 16, 0, 0);
    send(-300, 16, 0, 0);

    do_reset();
    repeat (3) send(10, 0, 16, 0);

    do_reset();
    send(5, 0, 0, 16);
    send(12, 0, 0, 16);

    do_reset();
    send(200, 16, 16, 0);
    send(200, 16, 16, 0);
    send(-10, 16, 16, 0);

    // Sample arriving mid-computation is dropped and latches overrun
    do_reset();
    chk("overrun_clear", int'(overrun_out), 0);
    sample_valid_in = 1'b1; error_in = 12'(50); kp_in = 8'(16); ki_in = '0; kd_in = '0;
    x.val = model(50, 16, 0, 0); x.cyc = cyc + 5; sbq.push_back(x);
    @(negedge clk); sample_valid_in = 1'b0;
    @(negedge clk); sample_valid_in = 1'b1; error_in = 12'(-999);
    @(negedge clk); sample_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("overrun_set", int'(overrun_out), 1);
    send(-40, 16, 16, 16);
    chk("overrun_sticky", int'(overrun_out), 1);

    // Reset landing in MUL_I: aborted sample must not produce a pulse
    sample_valid_in = 1'b1; error_in = 12'(77); kp_in = 8'(16);
    @(negedge clk); sample_valid_in = 1'b0;
    @(negedge clk); reset_in = 1'b1;
    @(negedge clk);
    @(negedge clk); reset_in = 1'b0;
    m_integ = 0; m_prev = 0; m_sat = 0; m_last = 0;
    repeat (8) @(negedge clk);
    check_idle_zero("midreset");

    // Random traffic: wide errors drive both integrator and output saturation
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      if (n % 20 == 10) do_reset();
      send($urandom_range(0, 4095) - 2048, $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("final_hold", int'(correction_out), m_last);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
